// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: the zero register index and the EX-stage control bundle.
package pipeline_pkg;

  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic [1:0] ALUOp;
    logic       ALUSrc;
    logic       branch;
    logic       memRead;
    logic       memWrite;
    logic       memtoReg;
    logic       regWrite;
  } ex_ctrl_t;

  localparam ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between the ID stage, the ID/EX register and its EX/forwarding consumers.
interface id_ex_stage_if #(
  parameter int N     = 64,
  parameter int CNT_W = 16
);
  logic [4:0]       IF_IDRegRn;
  logic [4:0]       IF_IDRegRm;
  logic [4:0]       ID_RegRd;
  logic [N-1:0]     ID_readData1;
  logic [N-1:0]     ID_readData2;
  logic [N-1:0]     ID_signImm;
  logic [N-1:0]     ID_PC;
  logic             ID_regWrite;
  logic             ID_memRead;
  logic             ID_memWrite;
  logic             ID_memtoReg;
  logic             ID_branch;
  logic             ID_ALUSrc;
  logic [1:0]       ID_ALUOp;
  logic             flush;

  logic [4:0]       ID_EXRegRn;
  logic [4:0]       ID_EXRegRm;
  logic [4:0]       ID_EXRegRd;
  logic [N-1:0]     ID_EXreadData1;
  logic [N-1:0]     ID_EXreadData2;
  logic [N-1:0]     ID_EXsignImm;
  logic [N-1:0]     ID_EXPC;
  logic             ID_EXregWrite;
  logic             ID_EXmemRead;
  logic             ID_EXmemWrite;
  logic             ID_EXmemtoReg;
  logic             ID_EXbranch;
  logic             ID_EXALUSrc;
  logic [1:0]       ID_EXALUOp;
  logic             stall;
  logic [CNT_W-1:0] stallCount;
  logic [CNT_W-1:0] flushCount;

  modport master (
    output IF_IDRegRn, IF_IDRegRm, ID_RegRd,
           ID_readData1, ID_readData2, ID_signImm, ID_PC,
           ID_regWrite, ID_memRead, ID_memWrite, ID_memtoReg, ID_branch, ID_ALUSrc,
           ID_ALUOp, flush,
    input  ID_EXRegRn, ID_EXRegRm, ID_EXRegRd,
           ID_EXreadData1, ID_EXreadData2, ID_EXsignImm, ID_EXPC,
           ID_EXregWrite, ID_EXmemRead, ID_EXmemWrite, ID_EXmemtoReg, ID_EXbranch, ID_EXALUSrc,
           ID_EXALUOp, stall, stallCount, flushCount
  );

  modport slave (
    input  IF_IDRegRn, IF_IDRegRm, ID_RegRd,
           ID_readData1, ID_readData2, ID_signImm, ID_PC,
           ID_regWrite, ID_memRead, ID_memWrite, ID_memtoReg, ID_branch, ID_ALUSrc,
           ID_ALUOp, flush,
    output ID_EXRegRn, ID_EXRegRm, ID_EXRegRd,
           ID_EXreadData1, ID_EXreadData2, ID_EXsignImm, ID_EXPC,
           ID_EXregWrite, ID_EXmemRead, ID_EXmemWrite, ID_EXmemtoReg, ID_EXbranch, ID_EXALUSrc,
           ID_EXALUOp, stall, stallCount, flushCount
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard decode: a load in ID/EX whose destination feeds either source in ID.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rn,
  input  logic [4:0] id_rm,
  output logic       hz
);

  // XZR is never really written, so a load targeting it cannot create a dependency.
  always_comb begin
    hz = ex_mem_read && (ex_rd != XZR) && ((ex_rd == id_rn) || (ex_rd == id_rm));
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash and
// saturating stall/flush event counters.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int N     = 64,
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          reset,
  id_ex_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ex_ctrl_t         ctrl_q, ctrl_d;
  logic [4:0]       rn_q, rn_d;
  logic [4:0]       rm_q, rm_d;
  logic [4:0]       rd_q, rd_d;
  logic [N-1:0]     data1_q, data1_d;
  logic [N-1:0]     data2_q, data2_d;
  logic [N-1:0]     imm_q, imm_d;
  logic [N-1:0]     pc_q, pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hz;
  logic             stall;

  hazard_detect u_hazard_detect (
    .ex_mem_read (ctrl_q.memRead),
    .ex_rd       (rd_q),
    .id_rn       (bus.IF_IDRegRn),
    .id_rm       (bus.IF_IDRegRm),
    .hz          (hz)
  );

  // A flush discards the ID instruction upstream, so holding PC/IF-ID would be wrong.
  assign stall = hz && !bus.flush;

  always_comb begin
    ctrl_d  = CTRL_BUBBLE;
    rn_d    = XZR;
    rm_d    = XZR;
    rd_d    = XZR;
    data1_d = '0;
    data2_d = '0;
    imm_d   = '0;
    pc_d    = '0;
    if (!(hz || bus.flush)) begin
      ctrl_d.ALUOp    = bus.ID_ALUOp;
      ctrl_d.ALUSrc   = bus.ID_ALUSrc;
      ctrl_d.branch   = bus.ID_branch;
      ctrl_d.memRead  = bus.ID_memRead;
      ctrl_d.memWrite = bus.ID_memWrite;
      ctrl_d.memtoReg = bus.ID_memtoReg;
      ctrl_d.regWrite = bus.ID_regWrite;
      rn_d            = bus.IF_IDRegRn;
      rm_d            = bus.IF_IDRegRm;
      rd_d            = bus.ID_RegRd;
      data1_d         = bus.ID_readData1;
      data2_d         = bus.ID_readData2;
      imm_d           = bus.ID_signImm;
      pc_d            = bus.ID_PC;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (bus.flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q      <= CTRL_BUBBLE;
      rn_q        <= XZR;
      rm_q        <= XZR;
      rd_q        <= XZR;
      data1_q     <= '0;
      data2_q     <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      rn_q        <= rn_d;
      rm_q        <= rm_d;
      rd_q        <= rd_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.ID_EXRegRn     = rn_q;
  assign bus.ID_EXRegRm     = rm_q;
  assign bus.ID_EXRegRd     = rd_q;
  assign bus.ID_EXreadData1 = data1_q;
  assign bus.ID_EXreadData2 = data2_q;
  assign bus.ID_EXsignImm   = imm_q;
  assign bus.ID_EXPC        = pc_q;
  assign bus.ID_EXregWrite  = ctrl_q.regWrite;
  assign bus.ID_EXmemRead   = ctrl_q.memRead;
  assign bus.ID_EXmemWrite  = ctrl_q.memWrite;
  assign bus.ID_EXmemtoReg  = ctrl_q.memtoReg;
  assign bus.ID_EXbranch    = ctrl_q.branch;
  assign bus.ID_EXALUSrc    = ctrl_q.ALUSrc;
  assign bus.ID_EXALUOp     = ctrl_q.ALUOp;
  assign bus.stall          = stall;
  assign bus.stallCount     = stall_cnt_q;
  assign bus.flushCount     = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load-use stalls, XZR handling, flush priority,
// reset behaviour and counter saturation (second instance with 4-bit counters).
module tb_id_ex_stage;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  id_ex_stage_if #(.N(64), .CNT_W(16)) bus ();
  id_ex_stage_if #(.N(64), .CNT_W(4))  sbus ();

  id_ex_stage #(.N(64), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  id_ex_stage #(.N(64), .CNT_W(4))  dut_sat (.clk(clk), .reset(reset), .bus(sbus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                          input logic mr, input logic mw, input logic rw, input logic m2r,
                          input logic [1:0] aluop, input logic [63:0] d1, input logic [63:0] pc);
    bus.IF_IDRegRn   = rn;
    bus.IF_IDRegRm   = rm;
    bus.ID_RegRd     = rd;
    bus.ID_memRead   = mr;
    bus.ID_memWrite  = mw;
    bus.ID_regWrite  = rw;
    bus.ID_memtoReg  = m2r;
    bus.ID_ALUSrc    = mr | mw;
    bus.ID_branch    = 1'b0;
    bus.ID_ALUOp     = aluop;
    bus.ID_readData1 = d1;
    bus.ID_readData2 = d1 ^ 64'hFFFF;
    bus.ID_signImm   = 64'd8;
    bus.ID_PC        = pc;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    drive_id(5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10, 64'h55, 64'h10);
    bus.flush = 1'b0;
    do_reset();
    if (bus.ID_EXregWrite !== 1'b0) begin errors++; $display("FAIL reset_regWrite got=%0b exp=0", bus.ID_EXregWrite); end
    checks++;
    if (bus.ID_EXmemRead !== 1'b0) begin errors++; $display("FAIL reset_memRead got=%0b exp=0", bus.ID_EXmemRead); end
    checks++;
    if (bus.ID_EXRegRn !== 5'd31 || bus.ID_EXRegRm !== 5'd31 || bus.ID_EXRegRd !== 5'd31) begin
      errors++; $display("FAIL reset_regnums got=%0d/%0d/%0d exp=31/31/31", bus.ID_EXRegRn, bus.ID_EXRegRm, bus.ID_EXRegRd);
    end
    checks++;
    if (bus.ID_EXreadData1 !== 64'd0 || bus.ID_EXPC !== 64'd0) begin
      errors++; $display("FAIL reset_data got=%h/%h exp=0/0", bus.ID_EXreadData1, bus.ID_EXPC);
    end
    checks++;
    if (bus.stallCount !== 16'd0 || bus.flushCount !== 16'd0) begin
      errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", bus.stallCount, bus.flushCount);
    end
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", bus.stall); end
    checks++;
    $display("test_reset done");
  endtask

  task automatic test_load_use_rn();
    // LDUR X1, [X2, #8]
    drive_id(5'd2, 5'd31, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 64'd100, 64'h40);
    tick();
    if (bus.ID_EXmemRead !== 1'b1 || bus.ID_EXRegRd !== 5'd1) begin
      errors++; $display("FAIL lu_rn_load_captured got=mr%0b rd%0d exp=mr1 rd1", bus.ID_EXmemRead, bus.ID_EXRegRd);
    end
    checks++;
    // ADD X2, X1, X3
    drive_id(5'd1, 5'd3, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 64'hAAAA, 64'h44);
    #1;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_rn_stall got=%0b exp=1", bus.stall); end
    checks++;
    tick();
    if (bus.ID_EXregWrite !== 1'b0 || bus.ID_EXRegRd !== 5'd31 || bus.ID_EXRegRn !== 5'd31 || bus.ID_EXreadData1 !== 64'd0) begin
      errors++; $display("FAIL lu_rn_bubble got=rw%0b rd%0d rn%0d d1=%h exp=rw0 rd31 rn31 d1=0",
                         bus.ID_EXregWrite, bus.ID_EXRegRd, bus.ID_EXRegRn, bus.ID_EXreadData1);
    end
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL lu_rn_stall_release got=%0b exp=0", bus.stall); end
    checks++;
    tick();
    if (bus.ID_EXRegRn !== 5'd1 || bus.ID_EXRegRm !== 5'd3 || bus.ID_EXRegRd !== 5'd2 ||
        bus.ID_EXALUOp !== 2'b10 || bus.ID_EXreadData1 !== 64'hAAAA || bus.ID_EXPC !== 64'h44) begin
      errors++; $display("FAIL lu_rn_add_enters got=rn%0d rm%0d rd%0d op%0d d1=%h pc=%h exp=rn1 rm3 rd2 op2 d1=aaaa pc=44",
                         bus.ID_EXRegRn, bus.ID_EXRegRm, bus.ID_EXRegRd, bus.ID_EXALUOp, bus.ID_EXreadData1, bus.ID_EXPC);
    end
    checks++;
    if (bus.stallCount !== 16'd1) begin errors++; $display("FAIL lu_rn_stallCount got=%0d exp=1", bus.stallCount); end
    checks++;
    $display("test_load_use_rn done");
  endtask

  task automatic test_no_false_stall();
    // LDUR X31 then ADD X2, X31, X31
    drive_id(5'd4, 5'd31, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 64'd7, 64'h80);
    tick();
    drive_id(5'd31, 5'd31, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 64'd9, 64'h84);
    #1;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL xzr_stall got=%0b exp=0", bus.stall); end
    checks++;
    tick();
    if (bus.ID_EXregWrite !== 1'b1 || bus.ID_EXRegRn !== 5'd31 || bus.ID_EXRegRd !== 5'd2) begin
      errors++; $display("FAIL xzr_captured got=rw%0b rn%0d rd%0d exp=rw1 rn31 rd2", bus.ID_EXregWrite, bus.ID_EXRegRn, bus.ID_EXRegRd);
    end
    checks++;
    // ADD X1 (no load) then SUB X4, X1, X1
    drive_id(5'd5, 5'd6, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 64'd1, 64'h88);
    tick();
    drive_id(5'd1, 5'd1, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 64'h1234, 64'h8C);
    #1;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL nonload_stall got=%0b exp=0", bus.stall); end
    checks++;
    tick();
    if (bus.ID_EXRegRn !== 5'd1 || bus.ID_EXRegRd !== 5'd4 || bus.ID_EXreadData1 !== 64'h1234 ||
        bus.ID_EXreadData2 !== (64'h1234 ^ 64'hFFFF) || bus.ID_EXPC !== 64'h8C) begin
      errors++; $display("FAIL nonload_captured got=rn%0d rd%0d d1=%h d2=%h pc=%h exp=rn1 rd4 d1=1234 d2=edcb pc=8c",
                         bus.ID_EXRegRn, bus.ID_EXRegRd, bus.ID_EXreadData1, bus.ID_EXreadData2, bus.ID_EXPC);
    end
    checks++;
    $display("test_no_false_stall done");
  endtask

  task automatic test_hazard_flush();
    do_reset();
    drive_id(5'd2, 5'd31, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 64'd3, 64'h100);
    tick();
    drive_id(5'd7, 5'd8, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 64'd4, 64'h104);
    bus.flush = 1'b1;
    #1;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL hzflush_stall got=%0b exp=0", bus.stall); end
    checks++;
    tick();
    bus.flush = 1'b0;
    if (bus.ID_EXregWrite !== 1'b0 || bus.ID_EXmemRead !== 1'b0 || bus.ID_EXRegRd !== 5'd31) begin
      errors++; $display("FAIL hzflush_bubble got=rw%0b mr%0b rd%0d exp=rw0 mr0 rd31", bus.ID_EXregWrite, bus.ID_EXmemRead, bus.ID_EXRegRd);
    end
    checks++;
    if (bus.flushCount !== 16'd1 || bus.stallCount !== 16'd0) begin
      errors++; $display("FAIL hzflush_counters got=f%0d s%0d exp=f1 s0", bus.flushCount, bus.stallCount);
    end
    checks++;
    $display("test_hazard_flush done");
  endtask

  task automatic test_load_use_rm();
    // LDUR X5 then STUR X5, [X9]
    drive_id(5'd2, 5'd31, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 64'd0, 64'h200);
    tick();
    drive_id(5'd9, 5'd5, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 64'h9000, 64'h204);
    #1;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_rm_stall got=%0b exp=1", bus.stall); end
    checks++;
    tick();
    if (bus.ID_EXmemWrite !== 1'b0 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL lu_rm_bubble got=mw%0b stall%0b exp=mw0 stall0", bus.ID_EXmemWrite, bus.stall);
    end
    checks++;
    tick();
    if (bus.ID_EXmemWrite !== 1'b1 || bus.ID_EXRegRm !== 5'd5 || bus.ID_EXRegRn !== 5'd9) begin
      errors++; $display("FAIL lu_rm_store_enters got=mw%0b rm%0d rn%0d exp=mw1 rm5 rn9", bus.ID_EXmemWrite, bus.ID_EXRegRm, bus.ID_EXRegRn);
    end
    checks++;
    $display("test_load_use_rm done");
  endtask

  task automatic test_reset_mid_stall();
    drive_id(5'd2, 5'd31, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 64'd0, 64'h300);
    tick();
    drive_id(5'd6, 5'd7, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 64'd1, 64'h304);
    #1;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL rstmid_stall_before got=%0b exp=1", bus.stall); end
    checks++;
    do_reset();
    if (bus.ID_EXmemRead !== 1'b0 || bus.ID_EXregWrite !== 1'b0 || bus.ID_EXRegRd !== 5'd31 || bus.ID_EXRegRn !== 5'd31) begin
      errors++; $display("FAIL rstmid_state got=mr%0b rw%0b rd%0d rn%0d exp=mr0 rw0 rd31 rn31",
                         bus.ID_EXmemRead, bus.ID_EXregWrite, bus.ID_EXRegRd, bus.ID_EXRegRn);
    end
    checks++;
    if (bus.stallCount !== 16'd0 || bus.flushCount !== 16'd0 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL rstmid_counters got=s%0d f%0d stall%0b exp=s0 f0 stall0", bus.stallCount, bus.flushCount, bus.stall);
    end
    checks++;
    $display("test_reset_mid_stall done");
  endtask

  task automatic test_back_to_back();
    // LDUR X1; LDUR X2,[X1]; ADD X3,X2,X4 -> two separate single stalls
    drive_id(5'd10, 5'd31, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 64'd0, 64'h400);
    tick();
    drive_id(5'd1, 5'd31, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 64'd0, 64'h404);
    #1;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL b2b_stall1 got=%0b exp=1", bus.stall); end
    checks++;
    tick();
    tick();
    if (bus.ID_EXmemRead !== 1'b1 || bus.ID_EXRegRd !== 5'd2) begin
      errors++; $display("FAIL b2b_load2_enters got=mr%0b rd%0d exp=mr1 rd2", bus.ID_EXmemRead, bus.ID_EXRegRd);
    end
    checks++;
    drive_id(5'd2, 5'd4, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 64'd0, 64'h408);
    #1;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL b2b_stall2 got=%0b exp=1", bus.stall); end
    checks++;
    tick();
    if (bus.stall !== 1'b0 || bus.stallCount !== 16'd2) begin
      errors++; $display("FAIL b2b_after got=stall%0b cnt%0d exp=stall0 cnt2", bus.stall, bus.stallCount);
    end
    checks++;
    $display("test_back_to_back done");
  endtask

  task automatic test_saturation();
    do_reset();
    if (sbus.flushCount !== 4'd0) begin errors++; $display("FAIL sat_start got=%0d exp=0", sbus.flushCount); end
    checks++;
    sbus.flush = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    if (sbus.flushCount !== 4'd14) begin errors++; $display("FAIL sat_14 got=%0d exp=14", sbus.flushCount); end
    checks++;
    for (int i = 0; i < 6; i++) tick();
    sbus.flush = 1'b0;
    if (sbus.flushCount !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", sbus.flushCount); end
    checks++;
    if (sbus.ID_EXregWrite !== 1'b0 || sbus.ID_EXRegRd !== 5'd31) begin
      errors++; $display("FAIL sat_bubble got=rw%0b rd%0d exp=rw0 rd31", sbus.ID_EXregWrite, sbus.ID_EXRegRd);
    end
    checks++;
    $display("test_saturation done");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    bus.flush = 1'b0;
    drive_id(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'd0, 64'd0);
    sbus.IF_IDRegRn   = 5'd0;
    sbus.IF_IDRegRm   = 5'd0;
    sbus.ID_RegRd     = 5'd12;
    sbus.ID_readData1 = 64'd1;
    sbus.ID_readData2 = 64'd2;
    sbus.ID_signImm   = 64'd3;
    sbus.ID_PC        = 64'd4;
    sbus.ID_regWrite  = 1'b1;
    sbus.ID_memRead   = 1'b0;
    sbus.ID_memWrite  = 1'b0;
    sbus.ID_memtoReg  = 1'b0;
    sbus.ID_branch    = 1'b0;
    sbus.ID_ALUSrc    = 1'b0;
    sbus.ID_ALUOp     = 2'b10;
    sbus.flush        = 1'b0;
    tick();

    test_reset();
    test_load_use_rn();
    test_no_false_stall();
    test_hazard_flush();
    test_load_use_rm();
    test_reset_mid_stall();
    test_back_to_back();
    test_saturation();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the five-stage LEGv8 core, with load-use hazard detection built in. It captures decoded operands, register numbers and control from ID, and presents them to EX and to the forwarding unit as `ID_EXRegRn`, `ID_EXRegRm` and `ID_EXRegRd`. It stalls PC and IF/ID for one cycle on a load-use dependency and inserts a bubble. It also squashes its contents on a branch flush, and keeps saturating stall/flush event counters.

## Interface
Parameters:
- `N`, 64, datapath width
- `CNT_W`, 16, width of each event counter

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low reset
- `IF_IDRegRn`, `IF_IDRegRm`  in  5  source registers of the instruction in ID (`Rm` is the post-Reg2Loc value)
- `ID_RegRd`  in  5  destination register of the instruction in ID
- `ID_readData1`, `ID_readData2`, `ID_signImm`, `ID_PC`  in  N  ID operands
- `ID_regWrite`, `ID_memRead`, `ID_memWrite`, `ID_memtoReg`, `ID_branch`, `ID_ALUSrc`  in  1  ID control
- `ID_ALUOp`  in  2  ID control
- `flush`  in  1  branch taken; squash the instruction in ID
- `ID_EXRegRn`, `ID_EXRegRm`, `ID_EXRegRd`  out  5  registered register numbers
- `ID_EXreadData1`, `ID_EXreadData2`, `ID_EXsignImm`, `ID_EXPC`  out  N  registered operands
- `ID_EXregWrite`, `ID_EXmemRead`, `ID_EXmemWrite`, `ID_EXmemtoReg`, `ID_EXbranch`, `ID_EXALUSrc`  out  1  registered control
- `ID_EXALUOp`  out  2  registered control
- `stall`  out  1  combinational; hold PC and IF/ID this cycle
- `stallCount`, `flushCount`  out  CNT_W  saturating event counters

## Operation
- **Hazard condition.** `hz = ID_EXmemRead && ID_EXRegRd != 31 && (ID_EXRegRd == IF_IDRegRn || ID_EXRegRd == IF_IDRegRm)`.
- **Stall output.** `stall = hz && !flush`.
- **Bubble.** A bubble is loaded when `hz || flush`:
  - all control outputs are set to 0;
  - `ID_EXRegRn`, `ID_EXRegRm` and `ID_EXRegRd` are set to 31, so the forwarding unit never matches a bubble;
  - data outputs are set to 0.
- **Normal load.** Otherwise all ID inputs are captured unchanged.
- **Flush has priority over the hazard.** When both occur, a bubble is loaded, `stall=0`, and the instruction in ID is discarded by the upstream flush.
- **`stallCount`.** Increments on every cycle where `stall=1`.
- **`flushCount`.** Increments on every cycle where `flush=1`.
- **Saturation.** Both counters saturate at 2^CNT_W−1 and never wrap.
- **Register 31 (XZR).**
  - A load whose destination is X31 never stalls.
  - A source of X31 matches only if the load's destination is also 31, which is excluded by the `!= 31` term.

## Timing
- **Reset** (`reset=0` at a rising edge, taking effect at that edge):
  - all control outputs = 0;
  - all register-number outputs = 31;
  - data outputs = 0;
  - both counters = 0;
  - `stall` = 0 combinationally from the following cycle.
- **Reset mid-operation** discards any pending bubble or stall. No stall is asserted in the cycle after reset releases, because `ID_EXmemRead = 0`.
- **Latency.** One cycle from ID inputs to outputs.
- **Stall decode.** `stall` is decoded in the same cycle from the current registered state; there is no extra latency.
- **Load-use sequence:**
  - cycle t: the LDUR is in ID/EX and the dependent instruction is in ID, so `stall=1`;
  - edge t+1: a bubble enters ID/EX while PC and IF/ID are held;
  - cycle t+1: `ID_EXmemRead = 0`, so `stall = 0`;
  - edge t+2: the dependent instruction enters EX and takes forwarding from MEM/WB.
- **Stall length.** Exactly one stall cycle per load-use pair. Back-to-back loads with chained dependencies each produce their own single stall.

## Structure
- Shared package `pipeline_pkg`:
  - `localparam XZR = 5'd31`;
  - packed struct `ex_ctrl_t` holding `ALUOp`, `ALUSrc`, `branch`, `memRead`, `memWrite`, `memtoReg`, `regWrite`;
  - `localparam ex_ctrl_t CTRL_BUBBLE = '0`.
- Sub-module `hazard_detect`: combinational, producing `hz`.
- The register and the counters stay in `id_ex_stage`.

## Test plan
- **Load-use, first operand.** LDUR X1 in ID/EX, ADD X2,X1,X3 in ID (`IF_IDRegRn=1`), `flush=0` → `stall=1` for one cycle. Next cycle: `ID_EXregWrite=0`, `ID_EXRegRd=31`, `stall=0`. Then the ADD appears with `ID_EXRegRn=1`. `stallCount=1`.
- **No false stall on X31 or on non-loads.**
  - LDUR X31 followed by ADD X2,X31,X31 → `stall=0`.
  - ADD X1 (`memRead=0`) followed by a use of X1 → `stall=0`, and the next cycle captures the ID inputs unchanged.
- **Hazard and flush together.** Hazard present and `flush=1` → `stall=0`, bubble loaded, `flushCount=1`, `stallCount=0`.
- **Load-use, second operand (store data).** LDUR X5 then STUR X5 (`IF_IDRegRm=5`) → `stall=1`.
- **Reset mid-stall.** Assert `reset=0` during the `stall=1` cycle → at the next cycle all controls are 0, register numbers are 31, counters are 0 and `stall=0`.
- **Counter saturation.** With `CNT_W=4`, drive `flush=1` for 20 cycles → `flushCount` holds at 15.
